// File: rtl/ll_telemetry_tx.sv
// Lander telemetry serializer: snapshots alt/vel/fuel/thrust on start and emits
// a fixed 20-byte ASCII frame "A dddd V s dddd F dddd T d CR LF" over a strobed byte port.
module ll_telemetry_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] alt,
    input  logic [15:0] vel,
    input  logic [15:0] fuel,
    input  logic [15:0] thrust,
    input  logic        txready,
    output logic [7:0]  txdata,
    output logic        txclk,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, SEND, STROBE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [15:0] alt_q, alt_d;
    logic [15:0] mag_q, mag_d;
    logic [7:0]  sign_q, sign_d;
    logic [15:0] fuel_q, fuel_d;
    logic [3:0]  thr_q, thr_d;
    logic [7:0]  txdata_q, txdata_d;
    logic        txclk_q, txclk_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [4:0]  nidx;
    logic [7:0]  nbyte;
    logic        vel_bad;
    logic        unused_thrust;

    assign unused_thrust = ^thrust[15:4];

    function automatic logic [7:0] digit_char(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
    endfunction

    function automatic logic [15:0] bcd_negate(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        logic [4:0]  d;
        r = '0;
        c = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            d = 5'd9 - {1'b0, v[4*i +: 4]} + {4'd0, c};
            if (d == 5'd10) begin
                r[4*i +: 4] = 4'd0;
                c = 1'b1;
            end else begin
                r[4*i +: 4] = d[3:0];
                c = 1'b0;
            end
        end
        return r;
    endfunction

    always_comb begin
        vel_bad = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (vel[4*i +: 4] > 4'd9) vel_bad = 1'b1;
        end
    end

    // Byte following the current index; loaded when STROBE hands off to SEND.
    assign nidx = idx_q + 5'd1;
    always_comb begin
        nbyte = 8'h00;
        case (nidx)
            5'd1:  nbyte = digit_char(alt_q[15:12]);
            5'd2:  nbyte = digit_char(alt_q[11:8]);
            5'd3:  nbyte = digit_char(alt_q[7:4]);
            5'd4:  nbyte = digit_char(alt_q[3:0]);
            5'd5:  nbyte = 8'h56;
            5'd6:  nbyte = sign_q;
            5'd7:  nbyte = digit_char(mag_q[15:12]);
            5'd8:  nbyte = digit_char(mag_q[11:8]);
            5'd9:  nbyte = digit_char(mag_q[7:4]);
            5'd10: nbyte = digit_char(mag_q[3:0]);
            5'd11: nbyte = 8'h46;
            5'd12: nbyte = digit_char(fuel_q[15:12]);
            5'd13: nbyte = digit_char(fuel_q[11:8]);
            5'd14: nbyte = digit_char(fuel_q[7:4]);
            5'd15: nbyte = digit_char(fuel_q[3:0]);
            5'd16: nbyte = 8'h54;
            5'd17: nbyte = digit_char(thr_q);
            5'd18: nbyte = 8'h0D;
            5'd19: nbyte = 8'h0A;
            default: nbyte = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        alt_d    = alt_q;
        mag_d    = mag_q;
        sign_d   = sign_q;
        fuel_d   = fuel_q;
        thr_d    = thr_q;
        txdata_d = txdata_q;
        txclk_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    alt_d    = alt;
                    fuel_d   = fuel;
                    thr_d    = thrust[3:0];
                    idx_d    = '0;
                    txdata_d = 8'h41;
                    state_d  = SEND;
                    // All-F magnitude makes every digit render as '?'.
                    if (vel_bad) begin
                        sign_d = 8'h3F;
                        mag_d  = '1;
                    end else if (vel[15:12] >= 4'd5) begin
                        sign_d = 8'h2D;
                        mag_d  = bcd_negate(vel);
                    end else begin
                        sign_d = 8'h2B;
                        mag_d  = vel;
                    end
                end
            end
            SEND: begin
                if (txready) begin
                    txclk_d = 1'b1;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                if (idx_q == 5'd19) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d    = nidx;
                    txdata_d = nbyte;
                    state_d  = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            alt_q    <= '0;
            mag_q    <= '0;
            sign_q   <= '0;
            fuel_q   <= '0;
            thr_q    <= '0;
            txdata_q <= '0;
            txclk_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            alt_q    <= alt_d;
            mag_q    <= mag_d;
            sign_q   <= sign_d;
            fuel_q   <= fuel_d;
            thr_q    <= thr_d;
            txdata_q <= txdata_d;
            txclk_q  <= txclk_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign txdata = txdata_q;
    assign txclk  = txclk_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_ll_telemetry_tx.sv
// Directed bench for ll_telemetry_tx: expected frame bytes are queued on start
// and compared against txdata at every txclk strobe.
module tb_ll_telemetry_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] alt, vel, fuel, thrust;
    logic        txready;
    logic [7:0]  txdata;
    logic        txclk, busy, done;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned strobe_cnt = 0;
    int unsigned done_cnt = 0;
    logic        prev_txclk = 1'b0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    ll_telemetry_tx dut (
        .clk(clk), .rst(rst), .start(start),
        .alt(alt), .vel(vel), .fuel(fuel), .thrust(thrust),
        .txready(txready), .txdata(txdata), .txclk(txclk),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dch(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
    endfunction

    // Velocity model works in decimal integers rather than digit-wise BCD.
    task automatic push_frame(input logic [15:0] a, input logic [15:0] v,
                              input logic [15:0] f, input logic [3:0] t);
        logic [7:0] fr[20];
        int         val, m;
        bit         ok;
        logic [3:0] nib;
        ok  = 1'b1;
        val = 0;
        for (int i = 3; i >= 0; i--) begin
            nib = v[4*i +: 4];
            if (nib > 4'd9) ok = 1'b0;
            val = val * 10 + int'(nib);
        end
        fr[0] = 8'h41;
        for (int i = 0; i < 4; i++) fr[1+i] = dch(a[12-4*i +: 4]);
        fr[5] = 8'h56;
        if (!ok) begin
            for (int i = 6; i <= 10; i++) fr[i] = 8'h3F;
        end else begin
            if (val >= 5000) begin
                fr[6] = 8'h2D;
                m = 10000 - val;
            end else begin
                fr[6] = 8'h2B;
                m = val;
            end
            fr[7]  = 8'h30 + 8'((m / 1000) % 10);
            fr[8]  = 8'h30 + 8'((m / 100) % 10);
            fr[9]  = 8'h30 + 8'((m / 10) % 10);
            fr[10] = 8'h30 + 8'(m % 10);
        end
        fr[11] = 8'h46;
        for (int i = 0; i < 4; i++) fr[12+i] = dch(f[12-4*i +: 4]);
        fr[16] = 8'h54;
        fr[17] = dch(t);
        fr[18] = 8'h0D;
        fr[19] = 8'h0A;
        for (int i = 0; i < 20; i++) exp_q.push_back(fr[i]);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_txclk = 1'b0;
        end else begin
            if (txclk) begin
                strobe_cnt++;
                chk("txclk_back_to_back", {31'b0, prev_txclk}, 32'd0);
                chk("strobe_has_expected_byte", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) chk("txdata_at_strobe", {24'b0, txdata}, {24'b0, exp_q.pop_front()});
            end
            if (done) done_cnt++;
            prev_txclk = txclk;
        end
    end

    // Pulses start across one rising edge; returns at the falling edge of cycle 1.
    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_queue_drained"}, exp_q.size(), 32'd0);
    endtask

    task automatic set_in(input logic [15:0] a, input logic [15:0] v,
                          input logic [15:0] f, input logic [15:0] t);
        alt = a; vel = v; fuel = f; thrust = t;
        push_frame(a, v, f, t[3:0]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; txready = 1'b1;
        alt = '0; vel = '0; fuel = '0; thrust = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_txdata", {24'b0, txdata}, 32'h00);
        chk("reset_txclk", {31'b0, txclk}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        rst = 1'b0;

        // Nominal frame with cycle-exact strobe/done timing.
        set_in(16'h4500, 16'h0000, 16'h0800, 16'h0005);
        kick();
        for (int c = 1; c <= 41; c++) begin
            chk($sformatf("nominal_txclk_c%0d", c), {31'b0, txclk},
                {31'b0, (c >= 2 && c <= 40 && (c % 2) == 0)});
            if (c == 1) chk("nominal_busy_c1", {31'b0, busy}, 32'd1);
            if (c == 1) chk("nominal_byte0_c1", {24'b0, txdata}, 32'h41);
            if (c == 40) chk("nominal_done_c40", {31'b0, done}, 32'd0);
            if (c == 41) begin
                chk("nominal_done_c41", {31'b0, done}, 32'd1);
                chk("nominal_busy_c41", {31'b0, busy}, 32'd0);
            end
            if (c < 41) @(negedge clk);
        end
        chk("nominal_queue_drained", exp_q.size(), 32'd0);

        set_in(16'h4500, 16'h9990, 16'h0800, 16'h0005);
        kick();
        wait_done("vel_9990");
        set_in(16'h4500, 16'h5000, 16'h0800, 16'h0005);
        kick();
        wait_done("vel_5000");
        set_in(16'h4500, 16'h4999, 16'h0800, 16'h0005);
        kick();
        wait_done("vel_4999");

        // Backpressure on byte 2 ('5'): ten cycles with txready low.
        set_in(16'h4500, 16'h0000, 16'h0800, 16'h0005);
        kick();
        repeat (4) @(negedge clk);
        chk("bp_byte2_offered", {24'b0, txdata}, 32'h35);
        txready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp_txclk_low_%0d", i), {31'b0, txclk}, 32'd0);
            chk($sformatf("bp_txdata_hold_%0d", i), {24'b0, txdata}, 32'h35);
        end
        txready = 1'b1;
        @(negedge clk);
        chk("bp_strobe_after_release", {31'b0, txclk}, 32'd1);
        chk("bp_txdata_at_strobe", {24'b0, txdata}, 32'h35);
        wait_done("backpressure");

        // Snapshot isolation and start ignored while busy.
        set_in(16'h4500, 16'h0000, 16'h0800, 16'h0005);
        @(negedge clk);
        strobe_cnt = 0;
        done_cnt = 0;
        kick();
        repeat (4) @(negedge clk);
        alt = 16'h1234;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done("snapshot");
        repeat (3) @(negedge clk);
        chk("snapshot_strobe_count", strobe_cnt, 32'd20);
        chk("snapshot_done_count", done_cnt, 32'd1);
        chk("snapshot_idle_busy", {31'b0, busy}, 32'd0);

        // Reset while byte 7 is offered.
        set_in(16'h4500, 16'h0000, 16'h0800, 16'h0005);
        kick();
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_txclk", {31'b0, txclk}, 32'd0);
        chk("rst_mid_txdata", {24'b0, txdata}, 32'h00);
        rst = 1'b0;
        exp_q.delete();
        set_in(16'h4500, 16'h0000, 16'h0800, 16'h0005);
        kick();
        chk("rst_restart_byte0", {24'b0, txdata}, 32'h41);
        wait_done("after_reset");

        // Non-BCD nibbles in fuel and velocity.
        set_in(16'h4500, 16'h00B0, 16'h0A12, 16'h0005);
        kick();
        wait_done("invalid_bcd");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
